// File: rtl/psum_ctrl_pkg.sv
// Shared types, default widths and config helpers for the psum requant controller.
// Saturation of the requantized result is selected by PSUM_REQ_SAT_EN.
package psum_ctrl_pkg;

  localparam int PSUM_W  = 16;
  localparam int ACC_W   = 21;
  localparam int OUT_W   = 8;
  localparam int MAX_ACC = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Zero and out-of-range counts fall back to the maximum depth.
  function automatic logic [2:0] clamp_acc_num(
    input logic [2:0] n,
    input int         max_acc
  );
    if (n == 3'd0 || int'(n) > max_acc)
      return 3'(max_acc);
    return n;
  endfunction

endpackage

// File: rtl/psum_requant_stage.sv
// Combinational arithmetic shift plus truncate or saturate to OUT_W bits.
// PSUM_REQ_SAT_EN defined: clip to the signed OUT_W range, else wrap.
module psum_requant_stage
  import psum_ctrl_pkg::*;
#(
  parameter int ACC_W = psum_ctrl_pkg::ACC_W,
  parameter int OUT_W = psum_ctrl_pkg::OUT_W
) (
  input  logic signed [ACC_W-1:0] x,
  input  logic        [3:0]       shift,
  output logic signed [OUT_W-1:0] y
);

  logic signed [ACC_W-1:0] sh;

  assign sh = x >>> shift;

`ifdef PSUM_REQ_SAT_EN
  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;

  // Clip the shifted value into the signed output range.
  always_comb begin
    y = sh[OUT_W-1:0];
    if (sh > HI)
      y = HI[OUT_W-1:0];
    else if (sh < LO)
      y = LO[OUT_W-1:0];
  end
`else
  logic unused_hi;

  assign unused_hi = ^sh[ACC_W-1:OUT_W];
  assign y = sh[OUT_W-1:0];
`endif

endmodule

// File: rtl/psum_requant_ctrl.sv
// Round-robin psum accumulator sharing one requantize path and output port.
// Build with PSUM_REQ_SAT_EN to saturate instead of wrap the 8-bit result.
module psum_requant_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PSUM_W  = psum_ctrl_pkg::PSUM_W,
  parameter int ACC_W   = psum_ctrl_pkg::ACC_W,
  parameter int OUT_W   = psum_ctrl_pkg::OUT_W,
  parameter int MAX_ACC = psum_ctrl_pkg::MAX_ACC,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [2:0]                cfg_acc_num,
  input  logic [3:0]                cfg_shift,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*PSUM_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic [IDW-1:0]            out_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  state_t state_q, state_d;

  logic [IDW-1:0]          rr_q;
  logic signed [ACC_W-1:0] acc_q [NUM_REQ];
  logic [2:0]              cnt_q [NUM_REQ];
  logic [2:0]              acc_num_q;
  logic [3:0]              shift_q;

  logic signed [PSUM_W-1:0] psum [NUM_REQ];

  logic                    out_free;
  logic                    gnt_any;
  logic [IDW-1:0]          gnt_idx;
  logic                    fl_any;
  logic [IDW-1:0]          fl_idx;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic                    complete;
  logic                    load_run;
  logic                    load_fl;
  logic signed [ACC_W-1:0] rq_in;
  logic signed [OUT_W-1:0] rq_out;

  assign out_free = !out_valid || out_ready;
  assign busy     = (state_q != IDLE);

  // Unpack the flat psum bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      psum[i] = req_data[i*PSUM_W +: PSUM_W];
  end

  // Round-robin grant starting at rr_q; withheld on output stall.
  always_comb begin
    logic [IDW-1:0] jj;
    int j;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    j         = 0;
    jj        = '0;
    if (state_q == RUN && out_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_q) + k;
        if (j >= NUM_REQ)
          j = j - NUM_REQ;
        jj = IDW'(j);
        if (!gnt_any && req_valid[jj]) begin
          gnt_any = 1'b1;
          gnt_idx = jj;
        end
      end
    end
    if (gnt_any)
      req_ready[gnt_idx] = 1'b1;
  end

  // Lowest-index requester still holding a partial sum.
  always_comb begin
    fl_any = 1'b0;
    fl_idx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (cnt_q[i] != 3'd0) begin
        fl_any = 1'b1;
        fl_idx = IDW'(i);
      end
    end
  end

  // Accumulate the granted psum onto its running sum.
  always_comb begin
    base = (cnt_q[gnt_idx] == 3'd0) ? '0 : acc_q[gnt_idx];
    sum  = base + {{(ACC_W-PSUM_W){psum[gnt_idx][PSUM_W-1]}},
                   psum[gnt_idx]};
    complete = (cnt_q[gnt_idx] + 3'd1) == acc_num_q;
    load_run = gnt_any && complete;
    load_fl  = (state_q == FLUSH) && fl_any && out_free;
    rq_in    = (state_q == FLUSH) ? acc_q[fl_idx] : sum;
  end

  psum_requant_stage #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .x     (rq_in),
    .shift (shift_q),
    .y     (rq_out)
  );

  // Next-state logic for the controller FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = RUN;
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   if (!fl_any && out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, config latch, round-robin pointer and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      acc_num_q <= 3'(MAX_ACC);
      shift_q   <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == FLUSH) && (state_d == IDLE);
      if (state_q == IDLE && cfg_start) begin
        acc_num_q <= clamp_acc_num(cfg_acc_num, MAX_ACC);
        shift_q   <= cfg_shift;
      end
      if (gnt_any)
        rr_q <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Per-requester partial sums and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_n) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end else if (gnt_any && gnt_idx == IDW'(i)) begin
        if (complete) begin
          acc_q[i] <= '0;
          cnt_q[i] <= '0;
        end else begin
          acc_q[i] <= sum;
          cnt_q[i] <= cnt_q[i] + 3'd1;
        end
      end else if (load_fl && fl_idx == IDW'(i)) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end
  end

  // Single output register; holds until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (load_run || load_fl) begin
      out_valid <= 1'b1;
      out_data  <= rq_out;
      out_id    <= load_fl ? fl_idx : gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/psum_requant_ctrl.md
# psum_requant_ctrl

Controller that shares one accumulate-and-requantize datapath among several PE-column psum streams. It accumulates a configured number (1–6) of 16-bit psums per requester. It then requantizes each completed 21-bit sum to 8 bits with a configurable arithmetic shift and emits it through a single valid/ready output port, tagged with the requester ID. It sits between the PE array psum outputs and the GLB write-back path.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- PSUM_W, 16, incoming psum width (8b x 8b product)
- ACC_W, 21, accumulator width
- OUT_W, 8, requantized output width
- MAX_ACC, 6, maximum accumulations per output

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_start  in  1  pulse; latches config and leaves IDLE
- cfg_acc_num  in  3  psums per output; 0 or >MAX_ACC is clamped to MAX_ACC
- cfg_shift  in  4  arithmetic right shift, 0..15
- flush  in  1  pulse; emit partial sums and finish
- req_valid  in  NUM_REQ  per-requester psum valid
- req_data  in  NUM_REQ*PSUM_W  signed psums; requester i occupies slice [i*PSUM_W +: PSUM_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer happens when req_valid[i] && req_ready[i]
- out_data  out  OUT_W  signed requantized result
- out_id  out  $clog2(NUM_REQ)  requester that produced out_data
- out_valid  out  1  output holding valid data
- out_ready  in  1  downstream accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when FLUSH completes

## Operation
- FSM states and transitions:
  - IDLE: cfg_start goes to RUN.
  - RUN: flush goes to FLUSH.
  - FLUSH: goes to IDLE once no requester has cnt != 0 and the output register is free. done is pulsed on that transition.
- Config is latched only in IDLE. cfg_start is ignored in RUN and FLUSH. flush is ignored in IDLE and FLUSH.
- Per-requester state: acc[i] (ACC_W, signed) and cnt[i] (0..MAX_ACC-1).
- Arbitration (RUN only):
  - Round-robin among asserted req_valid bits. Search starts at rr_ptr.
  - At most one grant per cycle. After a transfer, rr_ptr = granted index + 1, wrapping to 0.
- No grant is issued while out_valid && !out_ready (full stall, no skid).
- On transfer from requester i:
  - sum = (cnt[i]==0 ? 0 : acc[i]) + sign-extend(req_data_i).
  - If cnt[i]+1 == acc_num: the output register loads requant(sum) with out_id=i, acc[i] and cnt[i] clear.
  - Otherwise: acc[i]=sum, cnt[i]++.
- FLUSH:
  - No new grants.
  - Requesters with cnt != 0 are emitted in ascending index order, one per free output slot, using requant(acc[i]). Their acc and cnt are then cleared.
  - acc_num = 1 means every psum is emitted directly.
- requant(x):
  - y = x >>> shift (arithmetic shift).
  - Without saturation, out_data = y[OUT_W-1:0] (wrap).
- Arithmetic is all two's complement. ACC_W=21 cannot overflow for MAX_ACC=6 at PSUM_W=16.

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, req_ready=0, busy=0, done=0. State=IDLE, rr_ptr=0, all acc and cnt =0, latched acc_num=MAX_ACC, shift=0.
- req_ready is combinational from req_valid, rr_ptr, state, out_valid and out_ready.
- Latency: the completing psum is accepted at edge N, and out_valid is high in cycle N+1.
- Throughput: one psum per cycle. A result can be consumed and a new one loaded in the same cycle (out_ready high while out_valid high).
- A result is held stable until out_ready && out_valid.
- Reset asserted mid-operation aborts everything: partial sums are discarded and no done pulse is issued.
- A flush arriving in the same cycle as a transfer still processes that transfer; FLUSH begins the next cycle.

## Configuration
- PSUM_REQ_SAT_EN:
  - Defined: requant saturates y to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. -128..127.
  - Undefined: plain truncation to the low OUT_W bits, with no extra logic.

## Structure
- Package psum_ctrl_pkg holds:
  - State enum (IDLE, RUN, FLUSH).
  - Default widths PSUM_W/ACC_W/OUT_W/MAX_ACC.
  - Function clamp_acc_num.
- Sub-module psum_requant_stage holds the combinational shift plus optional saturate. It is instantiated once on the shared path and contains the PSUM_REQ_SAT_EN logic.

## Test plan
- acc_num=6, shift=2, requester 0 sends 100,200,300,400,500,600 -> one output 2100>>>2=525, truncated out_data=0x0D, out_id=0. With PSUM_REQ_SAT_EN: 127.
- All 4 requesters valid every cycle, acc_num=1, shift=0, data=i+1 -> outputs cycle through ids 0,1,2,3,0… with data 1,2,3,4.
- out_ready held low for 5 cycles while out_valid=1 -> req_ready all 0, and out_data/out_id stable; with out_ready=1 throughput resumes at one per cycle.
- acc_num=4: requester 1 sends 3 psums (-8 each), requester 3 sends 1 psum (40), then flush -> outputs id1=-24>>>shift, then id3, then done pulse and busy=0.
- cfg_acc_num=0 or 7 -> behaves as 6. cfg_start in RUN -> ignored.
- rst_n low mid-accumulation -> all outputs at reset values next cycle. A subsequent run starts with acc=0 (no stale partial sum).
